// File: rtl/anita4_l2_trigger_tx_if.sv
// rtl/anita4_l2_trigger_tx_if.sv - L1/control inputs and L2/scaler outputs of the L2 trigger transmitter
interface anita4_l2_trigger_tx_if #(
  parameter int NUM_TRIG = 4,
  parameter int NUM_IN   = 3,
  parameter int SCAL_W   = 16
);
  logic [NUM_TRIG*NUM_IN-1:0] L1_i;
  logic [NUM_TRIG*NUM_IN-1:0] mask_i;
  logic                       disable_i;
  logic [NUM_TRIG-1:0]        force_i;
  logic                       scal_latch_i;
  logic [NUM_TRIG-1:0]        L2_o;
  logic [NUM_TRIG-1:0]        L2B_o;
  logic [NUM_TRIG*SCAL_W-1:0] scal_o;

  modport master (
    output L1_i, mask_i, disable_i, force_i, scal_latch_i,
    input  L2_o, L2B_o, scal_o
  );

  modport slave (
    input  L1_i, mask_i, disable_i, force_i, scal_latch_i,
    output L2_o, L2B_o, scal_o
  );
endinterface

// File: rtl/anita4_l2_trigger_tx.sv
// rtl/anita4_l2_trigger_tx.sv - per-phi L2 majority trigger with fixed-width pulses, holdoff and scalers
module anita4_l2_trigger_tx #(
  parameter int NUM_TRIG  = 4,
  parameter int NUM_IN    = 3,
  parameter int MAJORITY  = 2,
  parameter int WINDOW    = 4,
  parameter int PULSE_LEN = 4,
  parameter int HOLDOFF   = 8,
  parameter int SCAL_W    = 16
) (
  input  logic                  clk250_i,
  input  logic                  rst_n_i,
  anita4_l2_trigger_tx_if.slave bus
);

  localparam int NB = NUM_TRIG * NUM_IN;
  localparam logic [3:0] WIN_LOAD = 4'(WINDOW);
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  logic [NB-1:0]              l1_q;
  logic [NB-1:0]              l1_prev;
  logic [NUM_TRIG-1:0]        force_q;
  logic [3:0]                 stretch [NB];
  logic [NB-1:0]              active;
  logic [NUM_TRIG-1:0]        coinc;
  state_t                     state [NUM_TRIG];
  logic [7:0]                 cnt [NUM_TRIG];
  logic [SCAL_W-1:0]          count [NUM_TRIG];
  logic [NUM_TRIG-1:0]        start;
  logic [NUM_TRIG-1:0]        l2_r;
  logic [NUM_TRIG-1:0]        l2b_r;
  logic [NUM_TRIG*SCAL_W-1:0] scal_r;

  function automatic int group_hits(input logic [NB-1:0] a, input int g);
    int c;
    c = 0;
    for (int j = 0; j < NUM_IN; j++) c += int'(a[g*NUM_IN + j]);
    return c;
  endfunction

  always_comb begin
    active = '0;
    for (int i = 0; i < NB; i++) active[i] = (stretch[i] != 4'd0);
  end

  always_comb begin
    start = '0;
    for (int g = 0; g < NUM_TRIG; g++)
      start[g] = (state[g] == IDLE) && coinc[g] && !bus.disable_i;
  end

  // Only an unmasked 0->1 transition (re)loads the stretch; a held level does not.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      l1_q    <= '0;
      l1_prev <= '0;
      force_q <= '0;
      coinc   <= '0;
      for (int i = 0; i < NB; i++) stretch[i] <= 4'd0;
    end else begin
      l1_q    <= bus.L1_i;
      l1_prev <= l1_q;
      force_q <= bus.force_i;
      for (int i = 0; i < NB; i++) begin
        if (bus.mask_i[i])                stretch[i] <= 4'd0;
        else if (l1_q[i] && !l1_prev[i]) stretch[i] <= WIN_LOAD;
        else if (stretch[i] != 4'd0)     stretch[i] <= stretch[i] - 4'd1;
      end
      for (int g = 0; g < NUM_TRIG; g++)
        coinc[g] <= (group_hits(active, g) >= MAJORITY) || force_q[g];
    end
  end

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      l2_r   <= '0;
      l2b_r  <= '0;
      scal_r <= '0;
      for (int g = 0; g < NUM_TRIG; g++) begin
        state[g] <= IDLE;
        cnt[g]   <= 8'd0;
        count[g] <= '0;
      end
    end else begin
      for (int g = 0; g < NUM_TRIG; g++) begin
        case (state[g])
          IDLE: begin
            if (start[g]) begin
              state[g] <= PULSE;
              cnt[g]   <= PULSE_LOAD;
              l2_r[g]  <= 1'b1;
              l2b_r[g] <= 1'b1;
            end
          end
          PULSE: begin
            if (cnt[g] == 8'd0) begin
              l2_r[g]  <= 1'b0;
              l2b_r[g] <= 1'b0;
              if (HOLDOFF == 0) begin
                state[g] <= IDLE;
              end else begin
                state[g] <= HOLD;
                cnt[g]   <= HOLD_LOAD;
              end
            end else begin
              cnt[g] <= cnt[g] - 8'd1;
            end
          end
          HOLD: begin
            if (cnt[g] == 8'd0) state[g] <= IDLE;
            else                cnt[g]   <= cnt[g] - 8'd1;
          end
          default: state[g] <= IDLE;
        endcase

        // A start coinciding with a latch belongs to the new interval.
        if (bus.scal_latch_i) begin
          scal_r[g*SCAL_W +: SCAL_W] <= count[g];
          count[g] <= {{(SCAL_W-1){1'b0}}, start[g]};
        end else if (start[g] && (count[g] != '1)) begin
          count[g] <= count[g] + SCAL_W'(1);
        end
      end
    end
  end

  assign bus.L2_o   = l2_r;
  assign bus.L2B_o  = l2b_r;
  assign bus.scal_o = scal_r;

endmodule

// File: tb/tb_anita4_l2_trigger_tx.sv
// tb/tb_anita4_l2_trigger_tx.sv - randomized and directed checks of the L2 trigger transmitter
module tb_anita4_l2_trigger_tx;
  localparam int NT = 4, NI = 3, MAJ = 2, W = 4, P = 4, H = 8, SW = 4;
  localparam int NB = NT * NI;
  localparam int MAXC = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  anita4_l2_trigger_tx_if #(.NUM_TRIG(NT), .NUM_IN(NI), .SCAL_W(SW)) bus ();

  anita4_l2_trigger_tx #(
    .NUM_TRIG(NT), .NUM_IN(NI), .MAJORITY(MAJ), .WINDOW(W),
    .PULSE_LEN(P), .HOLDOFF(H), .SCAL_W(SW)
  ) dut (
    .clk250_i(clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timestamp model: every L1 rise is remembered by cycle number; a pulse
  // occupies [start, start+P) and forbids another start before start+P+H+1.
  int k;
  int last [NB];
  logic [NB-1:0] s1, s2, act_m;
  logic [NT-1:0] coinc_m, force_d, exp_l2;
  int free_t [NT];
  int hi_until [NT];
  int cnt_m [NT];
  logic [NT*SW-1:0] exp_scal;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; s1 = '0; s2 = '0; act_m = '0; coinc_m = '0; force_d = '0;
      exp_l2 = '0; exp_scal = '0;
      for (int i = 0; i < NB; i++) last[i] = -1000;
      for (int g = 0; g < NT; g++) begin
        free_t[g] = 0; hi_until[g] = 0; cnt_m[g] = 0;
      end
    end else begin
      k++;
      for (int g = 0; g < NT; g++) begin
        bit st;
        int pc;
        st = 1'b0;
        if (coinc_m[g] && !bus.disable_i && k >= free_t[g]) begin
          st = 1'b1;
          free_t[g] = k + P + H + 1;
          hi_until[g] = k + P;
        end
        exp_l2[g] = (k < hi_until[g]);
        if (bus.scal_latch_i) begin
          exp_scal[g*SW +: SW] = SW'(cnt_m[g]);
          cnt_m[g] = st ? 1 : 0;
        end else if (st) begin
          cnt_m[g] = (cnt_m[g] < MAXC) ? cnt_m[g] + 1 : MAXC;
        end
        pc = 0;
        for (int j = 0; j < NI; j++) pc += act_m[g*NI + j] ? 1 : 0;
        coinc_m[g] = (pc >= MAJ) || force_d[g];
      end
      force_d = bus.force_i;
      for (int i = 0; i < NB; i++) begin
        if (bus.mask_i[i])         last[i] = -1000;
        else if (s1[i] && !s2[i])  last[i] = k;
        act_m[i] = (k - last[i] < W);
      end
      s2 = s1;
      s1 = bus.L1_i;
    end
  end

  always @(negedge clk) begin
    check("model_l2", {28'd0, bus.L2_o}, {28'd0, exp_l2});
    check("model_l2b", {28'd0, bus.L2B_o}, {28'd0, exp_l2});
    check("model_scal", {16'd0, bus.scal_o}, {16'd0, exp_scal});
  end

  task automatic wait_rise(input int g, input int maxc, output bit seen);
    logic prev;
    prev = bus.L2_o[g];
    seen = 1'b0;
    for (int c = 0; c < maxc && !seen; c++) begin
      @(negedge clk);
      if (!prev && bus.L2_o[g]) seen = 1'b1;
      prev = bus.L2_o[g];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic latch_pulse();
    bus.scal_latch_i = 1'b1;
    @(negedge clk);
    bus.scal_latch_i = 1'b0;
  endtask

  initial begin
    bit seen, ok;
    bus.L1_i = '0; bus.mask_i = '0; bus.disable_i = 1'b0;
    bus.force_i = '0; bus.scal_latch_i = 1'b0;
    idle(3);
    check("reset_l2", {28'd0, bus.L2_o}, 32'd0);
    check("reset_scal", {16'd0, bus.scal_o}, 32'd0);
    rst_n = 1'b1;
    idle(3);

    // bits 0,1 together: rise 3 cycles after registration, high 4, then holdoff
    bus.L1_i = 12'b011;
    @(negedge clk); bus.L1_i = '0;
    idle(2);
    check("t1_before", {31'd0, bus.L2_o[0]}, 32'd0);
    @(negedge clk);
    check("t1_rise", {30'd0, bus.L2_o[0], bus.L2B_o[0]}, 32'd3);
    ok = 1'b1;
    repeat (3) begin @(negedge clk); if (!bus.L2_o[0]) ok = 1'b0; end
    @(negedge clk);
    check("t1_len4", {30'd0, ok, bus.L2_o[0]}, 32'd2);
    bus.L1_i = 12'b011;
    @(negedge clk); bus.L1_i = '0;
    wait_rise(0, 10, seen);
    check("t1_holdoff_block", {31'd0, seen}, 32'd0);
    idle(10);

    // window edge: +3 coincides, +4 does not
    bus.L1_i = 12'b001; @(negedge clk); bus.L1_i = '0; idle(2);
    bus.L1_i = 12'b010; @(negedge clk); bus.L1_i = '0;
    wait_rise(0, 10, seen);
    check("t2_gap3", {31'd0, seen}, 32'd1);
    idle(16);
    bus.L1_i = 12'b001; @(negedge clk); bus.L1_i = '0; idle(3);
    bus.L1_i = 12'b010; @(negedge clk); bus.L1_i = '0;
    wait_rise(0, 10, seen);
    check("t2_gap4", {31'd0, seen}, 32'd0);
    idle(5);

    // coincidences every 5 cycles for 100 cycles
    latch_pulse();
    for (int r = 0; r < 20; r++) begin
      bus.L1_i = 12'b011; @(negedge clk); bus.L1_i = '0; idle(4);
    end
    idle(20);
    latch_pulse();
    check("t3_scaler8", {28'd0, bus.scal_o[3:0]}, 32'd8);

    // masked input cannot complete majority; force has 2-cycle latency
    bus.mask_i = 12'b010;
    bus.L1_i = 12'b011; @(negedge clk); bus.L1_i = '0;
    wait_rise(0, 10, seen);
    check("t4_mask", {31'd0, seen}, 32'd0);
    bus.mask_i = '0;
    bus.force_i = 4'b0100; @(negedge clk); bus.force_i = '0;
    @(negedge clk);
    check("t4_force_lat_lo", {31'd0, bus.L2_o[2]}, 32'd0);
    @(negedge clk);
    check("t4_force_lat_hi", {31'd0, bus.L2_o[2]}, 32'd1);
    ok = 1'b1;
    repeat (3) begin @(negedge clk); if (!bus.L2_o[2]) ok = 1'b0; end
    @(negedge clk);
    check("t4_force_len", {30'd0, ok, bus.L2_o[2]}, 32'd2);
    idle(12);

    // disable mid-pulse lets the pulse finish, then blocks new ones
    bus.force_i = 4'b0010; @(negedge clk); bus.force_i = '0;
    wait_rise(1, 10, seen);
    check("t5_start", {31'd0, seen}, 32'd1);
    bus.disable_i = 1'b1;
    ok = 1'b1;
    repeat (3) begin @(negedge clk); if (!bus.L2_o[1]) ok = 1'b0; end
    @(negedge clk);
    check("t5_len", {30'd0, ok, bus.L2_o[1]}, 32'd2);
    idle(15);
    bus.force_i = 4'b0010; @(negedge clk); bus.force_i = '0;
    wait_rise(1, 10, seen);
    check("t5_disabled", {31'd0, seen}, 32'd0);
    bus.disable_i = 1'b0;
    idle(5);

    // saturation, then latch on the very cycle of a start
    latch_pulse();
    bus.force_i = 4'b1000;
    idle(265);
    wait_rise(3, 20, seen);
    check("t6_sync", {31'd0, seen}, 32'd1);
    idle(12);
    bus.scal_latch_i = 1'b1;
    @(negedge clk);
    bus.scal_latch_i = 1'b0;
    bus.force_i = '0;
    check("t6_sat", {28'd0, bus.scal_o[15:12]}, 32'd15);
    check("t6_start_on_latch", {31'd0, bus.L2_o[3]}, 32'd1);
    idle(5);
    latch_pulse();
    check("t6_next_interval", {28'd0, bus.scal_o[15:12]}, 32'd1);
    idle(12);

    // async reset mid-pulse
    bus.force_i = 4'b0001; @(negedge clk); bus.force_i = '0;
    wait_rise(0, 10, seen);
    check("t7_start", {31'd0, seen}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("t7_reset_l2", {28'd0, bus.L2_o | bus.L2B_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.L1_i = 12'($urandom & $urandom);
      bus.mask_i = 12'($urandom & $urandom & $urandom & $urandom);
      bus.force_i = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'd0;
      bus.scal_latch_i = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) bus.disable_i = ~bus.disable_i;
      if (c == 1500) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    bus.L1_i = '0; bus.force_i = '0; bus.scal_latch_i = 1'b0;
    idle(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
